// File: rtl/aes_key_schedule_seq_if.sv
// Handshake and read-port bundle between the AES key schedule and its user.
// The master side issues start/key and round-key reads. The slave side (the key schedule) reports status and returns round keys.
// The optional abort input is present only when KEY_SCHED_ABORT_EN is defined.
interface aes_key_schedule_seq_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
`ifdef KEY_SCHED_ABORT_EN
    logic         abort;

    modport master (
        output start, key_len, key_in, rk_idx, abort,
        input  busy, done, err, nr, rk_valid, rk_data
    );
    modport slave (
        input  start, key_len, key_in, rk_idx, abort,
        output busy, done, err, nr, rk_valid, rk_data
    );
`else
    modport master (
        output start, key_len, key_in, rk_idx,
        input  busy, done, err, nr, rk_valid, rk_data
    );
    modport slave (
        input  start, key_len, key_in, rk_idx,
        output busy, done, err, nr, rk_valid, rk_data
    );
`endif
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule. It produces one 32-bit word per clock into a word buffer that is served through a round-key read port.
// done pulses 40/46/52 cycles after an accepted start. Round-key reads are combinational and return zero while busy.
// No backpressure: start is sampled only in IDLE and ignored while busy. Optional abort is enabled by macro KEY_SCHED_ABORT_EN.

// AES S-box applied bytewise: GF(2^8) inverse (x^254) followed by the affine map
module Sub_Word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        // square-and-multiply chain builds x^127, a final square gives x^254 = x^-1 (0 maps to 0)
        r = x;
        for (int k = 0; k < 6; k++) r = gmul(gmul(r, r), x);
        b = gmul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // substitute each of the four bytes independently
    always_comb begin
        word_o = '0;
        for (int k = 0; k < 4; k++) word_o[8*k +: 8] = sbox(word_i[8*k +: 8]);
    end
endmodule

// Round constant byte for rcon index 1..10 (0 outside that range)
module RC (
    input  logic [3:0] idx_i,
    output logic [7:0] rc_o
);
    // table lookup of x^(idx-1) in GF(2^8)
    always_comb begin
        rc_o = 8'h00;
        case (idx_i)
            4'd1:    rc_o = 8'h01;
            4'd2:    rc_o = 8'h02;
            4'd3:    rc_o = 8'h04;
            4'd4:    rc_o = 8'h08;
            4'd5:    rc_o = 8'h10;
            4'd6:    rc_o = 8'h20;
            4'd7:    rc_o = 8'h40;
            4'd8:    rc_o = 8'h80;
            4'd9:    rc_o = 8'h1b;
            4'd10:   rc_o = 8'h36;
            default: rc_o = 8'h00;
        endcase
    end
endmodule

module aes_key_schedule_seq #(
    parameter int MAX_NK         = 8,
    parameter int WORD_BUF_DEPTH = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_key_schedule_seq_if.slave  bus
);
    localparam int IW = $clog2(WORD_BUF_DEPTH);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t        state_q;
    logic [31:0]   w_q [WORD_BUF_DEPTH];
    logic [IW-1:0] i_q;
    logic [2:0]    j_q;
    logic [3:0]    rcon_idx_q;
    logic [3:0]    nk_q;
    logic [3:0]    sched_nr_q;
    logic [3:0]    nr_q;
    logic          has_keys_q;
    logic          done_q;
    logic          err_q;

    logic [3:0]    req_nk;
    logic [3:0]    req_nr;
    logic          req_legal;
    logic          accept;
    logic          abort_req;

    logic [IW-1:0] prev_idx;
    logic [IW-1:0] back_idx;
    logic [IW-1:0] last_idx;
    logic [31:0]   prev_w;
    logic [31:0]   back_w;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp;
    logic [31:0]   word_d;
    logic [7:0]    rc_val;
    logic          is_rot;
    logic          is_sub4;
    logic [2:0]    j_d;

    logic          rk_valid;
    logic [IW-1:0] rd_base;

`ifdef KEY_SCHED_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // decode requested key length; anything wider than the build supports is illegal
    always_comb begin
        req_nk    = 4'd4;
        req_nr    = 4'd10;
        req_legal = 1'b0;
        case (bus.key_len)
            2'd0:    begin req_nk = 4'd4; req_nr = 4'd10; req_legal = 1'b1; end
            2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; req_legal = 1'b1; end
            2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; req_legal = 1'b1; end
            default: begin req_nk = 4'd4; req_nr = 4'd10; req_legal = 1'b0; end
        endcase
        if (int'(req_nk) > MAX_NK) req_legal = 1'b0;
    end

    assign accept = (state_q == IDLE) && bus.start && req_legal;

    // last word index is T-1 = 4*Nr+3
    assign prev_idx = i_q - IW'(1);
    assign back_idx = i_q - IW'(nk_q);
    assign last_idx = IW'({sched_nr_q, 2'b11});
    assign prev_w   = w_q[prev_idx];
    assign back_w   = w_q[back_idx];
    assign is_rot   = (j_q == 3'd0);
    assign is_sub4  = (nk_q == 4'd8) && (j_q == 3'd4);
    assign sub_in   = is_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    assign j_d      = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;

    Sub_Word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    RC u_rc (
        .idx_i (rcon_idx_q),
        .rc_o  (rc_val)
    );

    // next expanded word; the single S-box serves both the rotate and the Nk=8 mid-block cases
    always_comb begin
        temp = prev_w;
        if (is_rot)       temp = sub_out ^ {rc_val, 24'h000000};
        else if (is_sub4) temp = sub_out;
        word_d = back_w ^ temp;
    end

    // control FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            has_keys_q <= 1'b0;
            nr_q       <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            i_q        <= '0;
            j_q        <= 3'd0;
            rcon_idx_q <= 4'd0;
            nk_q       <= 4'd4;
            sched_nr_q <= 4'd10;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (req_legal) begin
                            state_q    <= EXPAND;
                            has_keys_q <= 1'b0;
                            nk_q       <= req_nk;
                            sched_nr_q <= req_nr;
                            i_q        <= IW'(req_nk);
                            j_q        <= 3'd0;
                            rcon_idx_q <= 4'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    if (abort_req) begin
                        state_q    <= IDLE;
                        has_keys_q <= 1'b0;
                        nr_q       <= 4'd0;
                    end else begin
                        i_q <= i_q + IW'(1);
                        j_q <= j_d;
                        if (is_rot) rcon_idx_q <= rcon_idx_q + 4'd1;
                        if (i_q == last_idx) begin
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            has_keys_q <= 1'b1;
                            nr_q       <= sched_nr_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // word buffer: key words loaded on accept, one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(req_nk)) w_q[k] <= bus.key_in[255-32*k -: 32];
            end
        end else if (state_q == EXPAND && !abort_req) begin
            w_q[i_q] <= word_d;
        end
    end

    assign bus.busy = (state_q == EXPAND);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.nr   = nr_q;

    assign rk_valid     = (state_q == IDLE) && has_keys_q && (bus.rk_idx <= nr_q);
    assign bus.rk_valid = rk_valid;

    // round-key read: four consecutive words, zero unless a complete schedule is held
    always_comb begin
        rd_base     = IW'({bus.rk_idx, 2'b00});
        bus.rk_data = '0;
        if (rk_valid) begin
            bus.rk_data = {w_q[rd_base], w_q[rd_base + IW'(1)],
                           w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
        end
    end
endmodule
